imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32, datapath width in bits (min 24).
REQ-002 SHALL have parameter STAGES, default 2, pipeline latency in cycles (1..4).
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each item.
REQ-004 SHALL have parameter PFX_W, default 22, width of the left-aligned prefix field (< WORD_LENGTH).
REQ-005 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port flush  in  1  synchronous pipeline and prefix clear.
REQ-008 SHALL have port in_valid  in  1  an instruction is offered.
REQ-009 SHALL have port in_ready  out  1  the offered instruction is accepted this cycle.
REQ-010 SHALL have port instr  in  WORD_LENGTH  instruction word, bit 0 = MSB.
REQ-011 SHALL have port fmt  in  3  immediate format select.
REQ-012 SHALL have port in_tag  in  TAG_W  sideband tag.
REQ-013 SHALL have port out_valid  out  1  a result is presented.
REQ-014 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-015 SHALL have port y  out  WORD_LENGTH  generated immediate.
REQ-016 SHALL have port out_tag  out  TAG_W  tag of the presented result.
REQ-017 SHALL have port err  out  1  result came from COMBINE with no pending prefix.

Function
REQ-018 Field f = low F bits of instr; low-sign rule: s = rightmost bit of f, y = sign-extend({s, upper F-1 bits of f}).
REQ-019 fmt 0 ZERO: y = 0.
REQ-020 fmt 1 S14: low-sign rule, F = 14; fmt 2 S18: low-sign rule, F = 18.
REQ-021 fmt 3 U12: y = zero-extended low 12 bits.
REQ-022 fmt 4 L: y = low PFX_W bits shifted left by WORD_LENGTH-PFX_W, zero fill.
REQ-023 fmt 5 PREFIX: at acceptance, latch the fmt 4 value into the prefix register and set prefix_pending; the item still flows and outputs the fmt 4 value.
REQ-024 fmt 6 COMBINE: y = prefix OR zero-extended low WORD_LENGTH-PFX_W bits; prefix_pending cleared at acceptance; if not pending, prefix treated as 0 and err = 1.
REQ-025 fmt 7 reserved: y = 0, err = 1.
REQ-026 Prefix register read and written at acceptance in program order, so PREFIX followed back-to-back by COMBINE combines correctly.
REQ-027 A second PREFIX before COMBINE overwrites the prefix register.
REQ-028 Latency: an item accepted at cycle n presents out_valid at cycle n+STAGES when the output is not stalled.
REQ-029 Advance enable en = !out_valid OR out_ready; in_ready = en; all stages shift together when en = 1.
REQ-030 Bubbles propagate as invalid stages; throughput one item per cycle with out_ready held high.
REQ-031 While out_valid = 1 and out_ready = 0, y, out_tag, err SHALL hold stable.
REQ-032 flush: all stage valids and prefix_pending clear next cycle; an item offered in the flush cycle is dropped; in_ready = 0 in that cycle.

Reset
REQ-033 On rst: out_valid = 0, y = 0, out_tag = 0, err = 0, prefix register = 0, prefix_pending = 0, all stage valids = 0.
REQ-034 rst mid-stream discards all in-flight items; rst dominates flush; in_ready = 0 while rst = 1.

Structure
REQ-035 Format codes (0..7) and field widths 12/14/18 SHALL be constants in the shared VCPU32 definitions package.
REQ-036 Combinational extraction SHALL be one sub-module imm_extract (instr, fmt, prefix, pending -> value, err); the pipeline registers live in imm_gen_pipe.

Verification
REQ-037 fmt 1, instr low14 = 0x0003 -> y = 0xFFFFE001; low14 = 0x0002 -> y = 0x00000001.
REQ-038 fmt 3 low12 = 0xFFF -> 0x00000FFF; fmt 4 low22 = 0x3FFFFF -> 0xFFFFFC00.
REQ-039 PREFIX low22 = 0x12345 then COMBINE low10 = 0x3FF back-to-back -> 0x048D1400 then 0x048D17FF, err = 0.
REQ-040 COMBINE after reset, low10 = 0x005 -> y = 0x00000005, err = 1.
REQ-041 STAGES = 2, out_ready low 3 cycles with 4 items streaming -> in_ready low, outputs stable, no loss, tags 0..3 exit in order.
REQ-042 flush with 2 items in flight plus a pending prefix -> out_valid = 0 next cycle, following COMBINE reports err = 1.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared VCPU32 immediate-generation definitions: format codes and field widths.
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        FMT_ZERO    = 3'd0,
        FMT_S14     = 3'd1,
        FMT_S18     = 3'd2,
        FMT_U12     = 3'd3,
        FMT_L       = 3'd4,
        FMT_PREFIX  = 3'd5,
        FMT_COMBINE = 3'd6,
        FMT_RSVD    = 3'd7
    } imm_fmt_e;

    localparam int W_U12 = 12;
    localparam int W_S14 = 14;
    localparam int W_S18 = 18;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction for one instruction word.
module imm_extract
    import imm_gen_pipe_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int PFX_W       = 22
) (
    input  logic [WORD_LENGTH-1:0] instr,
    input  logic [2:0]             fmt,
    input  logic [WORD_LENGTH-1:0] prefix,
    input  logic                   pending,
    output logic [WORD_LENGTH-1:0] value,
    output logic                   err
);
    localparam int LO_W = WORD_LENGTH - PFX_W;

    logic [W_S14-1:0]       s14;
    logic [W_S18-1:0]       s18;
    logic [WORD_LENGTH-1:0] l_val;
    logic [WORD_LENGTH-1:0] lo_val;

    // Low-sign rule: the field's rightmost bit is the sign, rotated to the top.
    assign s14    = {instr[0], instr[W_S14-1:1]};
    assign s18    = {instr[0], instr[W_S18-1:1]};
    assign l_val  = {instr[PFX_W-1:0], {LO_W{1'b0}}};
    assign lo_val = {{PFX_W{1'b0}}, instr[LO_W-1:0]};

    always_comb begin
        value = '0;
        err   = 1'b0;
        case (imm_fmt_e'(fmt))
            FMT_S14:     value = {{(WORD_LENGTH-W_S14){s14[W_S14-1]}}, s14};
            FMT_S18:     value = {{(WORD_LENGTH-W_S18){s18[W_S18-1]}}, s18};
            FMT_U12:     value = {{(WORD_LENGTH-W_U12){1'b0}}, instr[W_U12-1:0]};
            FMT_L,
            FMT_PREFIX:  value = l_val;
            FMT_COMBINE: begin
                value = (pending ? prefix : '0) | lo_val;
                err   = !pending;
            end
            FMT_RSVD:    err = 1'b1;
            default:     value = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator pipeline: extraction at acceptance, STAGES register stages, valid/ready flow.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int STAGES      = 2,
    parameter int TAG_W       = 4,
    parameter int PFX_W       = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] instr,
    input  logic [2:0]             fmt,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] y,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   err
);
    logic                   en;
    logic                   accept;
    logic [STAGES-1:0]      vld_q;
    logic [STAGES-1:0]      err_q;
    logic [WORD_LENGTH-1:0] val_q [STAGES];
    logic [TAG_W-1:0]       tag_q [STAGES];
    logic [WORD_LENGTH-1:0] pfx_q, pfx_d;
    logic                   pend_q, pend_d;
    logic [WORD_LENGTH-1:0] ext_val;
    logic                   ext_err;

    assign out_valid = vld_q[STAGES-1];
    assign y         = val_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign err       = err_q[STAGES-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en && !flush && !rst;
    assign accept    = in_valid && in_ready;

    imm_extract #(
        .WORD_LENGTH(WORD_LENGTH),
        .PFX_W      (PFX_W)
    ) u_extract (
        .instr  (instr),
        .fmt    (fmt),
        .prefix (pfx_q),
        .pending(pend_q),
        .value  (ext_val),
        .err    (ext_err)
    );

    // Prefix state is touched only at acceptance, so program order is preserved
    // even for a PREFIX immediately followed by COMBINE.
    always_comb begin
        pfx_d  = pfx_q;
        pend_d = pend_q;
        if (flush) begin
            pfx_d  = '0;
            pend_d = 1'b0;
        end else if (accept) begin
            if (fmt == FMT_PREFIX) begin
                pfx_d  = ext_val;
                pend_d = 1'b1;
            end else if (fmt == FMT_COMBINE) begin
                pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            err_q  <= '0;
            pfx_q  <= '0;
            pend_q <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            pfx_q  <= pfx_d;
            pend_q <= pend_d;
            if (flush) begin
                vld_q <= '0;
            end else if (en) begin
                vld_q[0] <= accept;
                val_q[0] <= ext_val;
                tag_q[0] <= in_tag;
                err_q[0] <= ext_err;
                for (int i = 1; i < STAGES; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    val_q[i] <= val_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                    err_q[i] <= err_q[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe with a scoreboard of expected results.
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    localparam int WL = 32;
    localparam int ST = 2;
    localparam int TW = 4;
    localparam int PW = 22;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [WL-1:0] instr = '0;
    logic [2:0]    fmt = 3'd0;
    logic [TW-1:0] in_tag = '0;
    logic          in_ready, out_valid, err;
    logic [WL-1:0] y;
    logic [TW-1:0] out_tag;

    typedef struct {
        logic [WL-1:0] y;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   ntests = 0;
    int   nfail  = 0;

    logic          held = 1'b0;
    logic [WL-1:0] hy;
    logic [TW-1:0] ht;
    logic          he;

    always #5 clk = ~clk;

    imm_gen_pipe #(
        .WORD_LENGTH(WL),
        .STAGES     (ST),
        .TAG_W      (TW),
        .PFX_W      (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .fmt      (fmt),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .out_tag  (out_tag),
        .err      (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one item, wait (bounded) for acceptance, then record its expected result.
    task automatic send(input logic [WL-1:0] i, input logic [2:0] f, input logic [TW-1:0] t,
                        input logic [WL-1:0] ey, input logic ee);
        int n = 0;
        instr = i; fmt = f; in_tag = t; in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("accept", in_ready, 1'b1);
        if (in_ready === 1'b1) sb.push_back('{ey, t, ee});
        @(posedge clk); #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Consumer side: pop on handshake, and hold-stability while stalled.
    always @(negedge clk) begin
        if (rst || flush) begin
            held = 1'b0;
        end else if (out_valid === 1'b1) begin
            if (held) begin
                check("stall_y", y, hy);
                check("stall_tag", out_tag, ht);
                check("stall_err", err, he);
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", out_valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("y", y, mon_e.y);
                    check("tag", out_tag, mon_e.tag);
                    check("err", err, mon_e.err);
                end
            end
            held = !out_ready;
            hy = y; ht = out_tag; he = err;
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        int n;
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y, '0);
        check("rst_out_tag", out_tag, '0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Format coverage, back-to-back at full throughput
        send(32'h0000_0003, FMT_S14,     4'd1,  32'hFFFF_E001, 1'b0);
        send(32'hABCD_0002, FMT_S14,     4'd2,  32'h0000_0001, 1'b0);
        send(32'h0000_0001, FMT_S18,     4'd3,  32'hFFFE_0000, 1'b0);
        send(32'h0003_FFFE, FMT_S18,     4'd4,  32'h0001_FFFF, 1'b0);
        send(32'hFFFF_FFFF, FMT_U12,     4'd5,  32'h0000_0FFF, 1'b0);
        send(32'h003F_FFFF, FMT_L,       4'd6,  32'hFFFF_FC00, 1'b0);
        send(32'hFFFF_FFFF, FMT_ZERO,    4'd7,  32'h0000_0000, 1'b0);
        send(32'h1234_5678, FMT_RSVD,    4'd8,  32'h0000_0000, 1'b1);
        send(32'h0001_2345, FMT_PREFIX,  4'd9,  32'h048D_1400, 1'b0);
        send(32'hFFFF_FFFF, FMT_COMBINE, 4'd10, 32'h048D_17FF, 1'b0);
        send(32'h0000_0005, FMT_COMBINE, 4'd11, 32'h0000_0005, 1'b1);
        send(32'h0000_0001, FMT_PREFIX,  4'd12, 32'h0000_0400, 1'b0);
        send(32'h0000_0002, FMT_PREFIX,  4'd13, 32'h0000_0800, 1'b0);
        send(32'h0000_0001, FMT_COMBINE, 4'd14, 32'h0000_0801, 1'b0);
        in_valid = 1'b0;
        cyc(4);

        // Latency of a lone item
        send(32'h0000_0ABC, FMT_U12, 4'd15, 32'h0000_0ABC, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_n1", out_valid, 1'b0);
        @(negedge clk);
        check("lat_n2", out_valid, 1'b1);
        cyc(3);

        // Backpressure: consumer stalls 3 cycles with 4 items streaming
        out_ready = 1'b0;
        send(32'h0000_0100, FMT_U12, 4'd0, 32'h0000_0100, 1'b0);
        send(32'h0000_0101, FMT_U12, 4'd1, 32'h0000_0101, 1'b0);
        instr = 32'h0000_0102; fmt = FMT_U12; in_tag = 4'd2; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'h0000_0102, FMT_U12, 4'd2, 32'h0000_0102, 1'b0);
        send(32'h0000_0103, FMT_U12, 4'd3, 32'h0000_0103, 1'b0);
        in_valid = 1'b0;
        cyc(5);

        // Flush with two items in flight and a pending prefix
        out_ready = 1'b0;
        send(32'h0001_2345, FMT_PREFIX, 4'd4, 32'h048D_1400, 1'b0);
        send(32'h0000_0007, FMT_U12,    4'd5, 32'h0000_0007, 1'b0);
        flush = 1'b1;
        instr = 32'h0000_0009; fmt = FMT_U12; in_tag = 4'd6; in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 1'b0);
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h0000_0005, FMT_COMBINE, 4'd7, 32'h0000_0005, 1'b1);
        in_valid = 1'b0;
        cyc(4);

        // Reset mid-stream discards in-flight items and the pending prefix
        out_ready = 1'b0;
        send(32'h0000_0001, FMT_PREFIX, 4'd8, 32'h0000_0400, 1'b0);
        send(32'h0000_0002, FMT_U12,    4'd9, 32'h0000_0002, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1'b0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h0000_03FF, FMT_COMBINE, 4'd10, 32'h0000_03FF, 1'b1);
        in_valid = 1'b0;

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
